// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction/PC buffer between fetch and decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a pushed word
// straight to the outputs when the queue is empty (latency 0).
module fetch_queue #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_in,
    input  logic [WORD_WIDTH-1:0]   instruction_in,
    input  logic [WORD_WIDTH-1:0]   rm0_in,
    input  logic                    pop_in,
    input  logic                    flush_in,
    output logic [WORD_WIDTH-1:0]   instruction_out,
    output logic [WORD_WIDTH-1:0]   rm0_out,
    output logic                    active_out,
    output logic                    full_out,
    output logic [$clog2(DEPTH):0]  count_out,
    output logic                    drop_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            drop;

    logic            empty;
    logic            full;
    logic            pop_fire;
    logic            push_accept;
    logic            push_store;
    logic            drop_next;
    entry_t          head;

    // Handshake decode: what the coming edge will do to the queue.
    always_comb begin
        empty       = (count == '0);
        full        = (count == CW'(DEPTH));
        pop_fire    = pop_in && !empty;
        push_accept = push_in && (!full || pop_fire);
`ifdef FETCH_QUEUE_BYPASS_EN
        // A word pushed into an empty queue and popped at once is consumed
        // through the bypass and never written.
        push_store  = push_accept && !(empty && pop_in);
`else
        push_store  = push_accept;
`endif
        drop_next   = push_in && full && !pop_in && !flush_in;
        head        = mem[rd_ptr];
    end

    // Entry storage; cleared on reset so the head reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_store && !flush_in) begin
            mem[wr_ptr] <= '{pc: rm0_in, instr: instruction_in};
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_store, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle pulse flagging a push rejected because the queue was full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else begin
            drop <= drop_next;
        end
    end

    // Head presentation; zero when nothing valid is available.
    always_comb begin
        instruction_out = '0;
        rm0_out         = '0;
        active_out      = !empty;
        full_out        = full;
        count_out       = count;
        drop_out        = drop;
        if (!empty) begin
            instruction_out = head.instr;
            rm0_out         = head.pc;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (push_in) begin
            instruction_out = instruction_in;
            rm0_out         = rm0_in;
            active_out      = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus random traffic against a
// queue-based reference model of fetch_queue.
module tb_fetch_queue;

    localparam int W = 32;
    localparam int D = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          push_in;
    logic [W-1:0]  instruction_in;
    logic [W-1:0]  rm0_in;
    logic          pop_in;
    logic          flush_in;
    logic [W-1:0]  instruction_out;
    logic [W-1:0]  rm0_out;
    logic          active_out;
    logic          full_out;
    logic [2:0]    count_out;
    logic          drop_out;

    int            total;
    int            bad;
    logic [63:0]   mq [$];      // {pc, instr}, front = head
    logic          exp_drop;

    fetch_queue #(.WORD_WIDTH(W), .DEPTH(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .push_in         (push_in),
        .instruction_in  (instruction_in),
        .rm0_in          (rm0_in),
        .pop_in          (pop_in),
        .flush_in        (flush_in),
        .instruction_out (instruction_out),
        .rm0_out         (rm0_out),
        .active_out      (active_out),
        .full_out        (full_out),
        .count_out       (count_out),
        .drop_out        (drop_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every output with what the model says it should be now.
    task automatic check_all(string tag);
        int          n;
        logic [63:0] e_instr;
        logic [63:0] e_pc;
        logic        e_act;
        n       = mq.size();
        e_instr = 64'h0;
        e_pc    = 64'h0;
        e_act   = (n != 0);
        if (n != 0) begin
            e_instr = {32'h0, mq[0][31:0]};
            e_pc    = {32'h0, mq[0][63:32]};
        end else if (BYP && push_in) begin
            e_instr = {32'h0, instruction_in};
            e_pc    = {32'h0, rm0_in};
            e_act   = 1'b1;
        end
        check({tag, ":count"},  64'(count_out),       64'(n));
        check({tag, ":full"},   64'(full_out),        64'(n == D));
        check({tag, ":active"}, 64'(active_out),      64'(e_act));
        check({tag, ":instr"},  64'(instruction_out), e_instr);
        check({tag, ":pc"},     64'(rm0_out),         e_pc);
        check({tag, ":drop"},   64'(drop_out),        64'(exp_drop));
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        int n;
        bit popq;
        bit acc;
        n = mq.size();
        if (flush_in) begin
            mq.delete();
            exp_drop = 1'b0;
        end else begin
            popq     = pop_in && (n > 0);
            acc      = push_in && ((n < D) || popq);
            exp_drop = push_in && (n == D) && !pop_in;
            if (!(BYP && n == 0 && push_in && pop_in)) begin
                if (popq) void'(mq.pop_front());
                if (acc)  mq.push_back({rm0_in, instruction_in});
            end
        end
    endtask

    task automatic cyc_begin(string tag, bit pu, bit po, bit fl,
                             logic [W-1:0] ins, logic [W-1:0] pc);
        @(negedge clk);
        push_in        = pu;
        pop_in         = po;
        flush_in       = fl;
        instruction_in = ins;
        rm0_in         = pc;
        #1;
        check_all(tag);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_edge();
    endtask

    task automatic step(string tag, bit pu, bit po, bit fl,
                        logic [W-1:0] ins, logic [W-1:0] pc);
        cyc_begin(tag, pu, po, fl, ins, pc);
        cyc_end();
    endtask

    task automatic fill(string tag, int n, logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b1, 1'b0, 1'b0, base + W'(i), W'(4 * i));
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        exp_drop       = 1'b0;
        rst_n          = 1'b0;
        push_in        = 1'b0;
        pop_in         = 1'b0;
        flush_in       = 1'b0;
        instruction_in = '0;
        rm0_in         = '0;
        #12;
        check("rst:count",  64'(count_out),       64'd0);
        check("rst:active", 64'(active_out),      64'd0);
        check("rst:full",   64'(full_out),        64'd0);
        check("rst:instr",  64'(instruction_out), 64'd0);
        check("rst:pc",     64'(rm0_out),         64'd0);
        check("rst:drop",   64'(drop_out),        64'd0);
        rst_n = 1'b1;

        // Fill to capacity.
        fill("fill", 4, 32'hA0);
        cyc_begin("full", 1'b0, 1'b0, 1'b0, '0, '0);
        check("full:flag",  64'(full_out),        64'd1);
        check("full:count", 64'(count_out),       64'd4);
        check("full:instr", 64'(instruction_out), 64'hA0);
        check("full:pc",    64'(rm0_out),         64'h0);
        cyc_end();

        // Overflow push is dropped with a one-cycle flag.
        step("ovf", 1'b1, 1'b0, 1'b0, 32'hB0, 32'h10);
        cyc_begin("drop1", 1'b0, 1'b0, 1'b0, '0, '0);
        check("drop1:flag", 64'(drop_out), 64'd1);
        cyc_end();
        cyc_begin("drop0", 1'b0, 1'b0, 1'b0, '0, '0);
        check("drop0:flag", 64'(drop_out), 64'd0);
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin("drain", 1'b0, 1'b1, 1'b0, '0, '0);
            check("drain:instr", 64'(instruction_out), 64'(32'hA0 + i));
            cyc_end();
        end
        cyc_begin("empty", 1'b0, 1'b0, 1'b0, '0, '0);
        check("empty:active", 64'(active_out), 64'd0);
        cyc_end();

        // Push and pop together while full, then drain across the wrap.
        fill("fill2", 4, 32'hA0);
        step("pp", 1'b1, 1'b1, 1'b0, 32'hB0, 32'h10);
        cyc_begin("pp:hold", 1'b0, 1'b0, 1'b0, '0, '0);
        check("pp:count", 64'(count_out), 64'd4);
        cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_begin("wrap", 1'b0, 1'b1, 1'b0, '0, '0);
            check("wrap:instr", 64'(instruction_out),
                  (i == 3) ? 64'hB0 : 64'(32'hA1 + i));
            cyc_end();
        end

        // Flush beats a same-cycle push.
        fill("fill3", 2, 32'hD0);
        step("flush", 1'b1, 1'b0, 1'b1, 32'hE0, 32'h20);
        cyc_begin("postflush", 1'b0, 1'b0, 1'b0, '0, '0);
        check("flush:count",  64'(count_out),       64'd0);
        check("flush:active", 64'(active_out),      64'd0);
        check("flush:instr",  64'(instruction_out), 64'd0);
        check("flush:drop",   64'(drop_out),        64'd0);
        cyc_end();

        // Asynchronous reset between edges at count 3.
        fill("fill4", 3, 32'h90);
        @(negedge clk);
        push_in = 1'b0;
        pop_in  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:count",  64'(count_out),       64'd0);
        check("arst:active", 64'(active_out),      64'd0);
        check("arst:instr",  64'(instruction_out), 64'd0);
        check("arst:pc",     64'(rm0_out),         64'd0);
        mq.delete();
        exp_drop = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step("after_rst", 1'b1, 1'b0, 1'b0, 32'hF0, 32'h30);
        cyc_begin("after_rst:hd", 1'b0, 1'b0, 1'b0, '0, '0);
        check("after_rst:instr", 64'(instruction_out), 64'hF0);
        check("after_rst:count", 64'(count_out),       64'd1);
        cyc_end();
        step("after_rst:pop", 1'b0, 1'b1, 1'b0, '0, '0);

        // Empty queue, push and pop in the same cycle.
        cyc_begin("byp", 1'b1, 1'b1, 1'b0, 32'hC0, 32'h40);
        check("byp:instr",  64'(instruction_out), BYP ? 64'hC0 : 64'h0);
        check("byp:active", 64'(active_out),      64'(BYP));
        check("byp:count",  64'(count_out),       64'd0);
        cyc_end();
        cyc_begin("byp:next", 1'b0, 1'b0, 1'b0, '0, '0);
        check("byp:next_instr", 64'(instruction_out), BYP ? 64'h0 : 64'hC0);
        check("byp:next_count", 64'(count_out),       BYP ? 64'd0 : 64'd1);
        cyc_end();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step("rnd", $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 4, $urandom(), $urandom());
        end
        step("final", 1'b0, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
